// File: rtl/add_ctrl_pkg.sv
// Shared definitions for the word-serial adder controller.
// Holds the state encoding and the slice-index width helper.
package add_ctrl_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_ADD  = ST_ADD,
      S_DONE = ST_DONE
   } state_t;

   // A single-slice operand still needs a 1-bit index register.
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/word_serial_add_ctrl_adder.sv
// Shared N-bit combinational adder slice; outputs are unregistered.
module word_serial_add_ctrl_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/word_serial_add_ctrl.sv
// Word-serial W-bit adder: one N-bit slice per cycle through a shared adder,
// LSB slice first, with the inter-slice carry held in a register.
module word_serial_add_ctrl
   import add_ctrl_pkg::*;
#(
   parameter int N     = 4,
   parameter int WORDS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N*WORDS-1:0] a,
   input  logic [N*WORDS-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N*WORDS-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int W  = N * WORDS;
   localparam int IW = idx_width(WORDS);
   localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q;
   logic            carry_q;
   logic [W-1:0]    a_r, b_r;
   logic [N-1:0]    sl_a, sl_b, sl_s;
   logic            sl_co;
   logic            last;

   assign last = (idx_q == IDX_LAST);
   assign sl_a = a_r[int'(idx_q)*N +: N];
   assign sl_b = b_r[int'(idx_q)*N +: N];

   word_serial_add_ctrl_adder #(.N(N)) u_adder (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (carry_q),
      .s    (sl_s),
      .cout (sl_co)
   );

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = S_ADD;
         end
         S_ADD: begin
            busy = 1'b1;
            if (last) state_d = S_DONE;
         end
         S_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Operand capture is pure data; it is only read while in ADD.
   always_ff @(posedge clk) begin
      if (state_q == S_IDLE && in_valid) begin
         a_r <= a;
         b_r <= b;
      end
   end

   // Sum is built up slice by slice and left in place after the handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  carry_q <= cin;
                  idx_q   <= '0;
               end
            end
            S_ADD: begin
               sum[int'(idx_q)*N +: N] <= sl_s;
               carry_q                 <= sl_co;
               if (last) begin
                  cout  <= sl_co;
                  idx_q <= '0;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
